// File: rtl/arilla_arb_pkg.sv
// Shared types and helpers for the arilla bus arbiter.
package arilla_arb_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_WAIT, ARB_DATA} arb_state_t;

   localparam int unsigned MAX_MASTERS = 8;

   // Index width that never collapses to zero bits, even for n <= 2.
   function automatic int unsigned clog2_min1(input int unsigned n);
      clog2_min1 = 1;
      for (int unsigned i = 1; i < 32; i++)
         if ((32'd1 << i) < n) clog2_min1 = i + 1;
   endfunction

endpackage

// File: rtl/arilla_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester strictly above last_owner, else lowest requester.
module rr_picker
   import arilla_arb_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 2,
   parameter int unsigned OW          = clog2_min1(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [OW-1:0]          last_owner,
   output logic [OW-1:0]          winner,
   output logic                   any_req
);

   logic [NUM_MASTERS-1:0] hi_req;

   always_comb begin
      hi_req  = '0;
      winner  = '0;
      any_req = |req;
      for (int unsigned i = 0; i < NUM_MASTERS; i++)
         hi_req[i] = req[i] && (i > 32'(last_owner));
      // Lowest set bit wins; the masked pass overrides when anything sits above last_owner.
      for (int unsigned i = NUM_MASTERS; i > 0; i--)
         if (req[i-1]) winner = OW'(i - 1);
      for (int unsigned i = NUM_MASTERS; i > 0; i--)
         if (hi_req[i-1]) winner = OW'(i - 1);
   end

endmodule

// File: rtl/arilla_bus_arbiter.sv
// Round-robin arbiter for the shared arilla bus; one-hot grant held across each transfer.
// Optional WAIT watchdog: define ARILLA_ARB_TIMEOUT_EN to build the timeout counter and bus_error.
module arilla_bus_arbiter
   import arilla_arb_pkg::*;
#(
   parameter int unsigned NUM_MASTERS    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_MASTERS-1:0]         req,
   input  logic [NUM_MASTERS-1:0]         lock,
   input  logic                           bus_read,
   input  logic                           bus_write,
   input  logic                           bus_hit,
   output logic [NUM_MASTERS-1:0]         available,
   output logic [$clog2(NUM_MASTERS)-1:0] owner,
   output logic                           busy,
   output logic                           bus_error
);

   localparam int unsigned OW = clog2_min1(NUM_MASTERS);

   arb_state_t    state;
   logic [OW-1:0] owner_q;
   logic [OW-1:0] last_owner;
   logic [OW-1:0] winner;
   logic          any_req;
   logic          strobe;
   logic          keep;
   logic          timeout_hit;

   rr_picker #(
      .NUM_MASTERS (NUM_MASTERS),
      .OW          (OW)
   ) u_picker (
      .req        (req),
      .last_owner (last_owner),
      .winner     (winner),
      .any_req    (any_req)
   );

   assign strobe = bus_read | bus_write;
   assign keep   = lock[owner_q] & req[owner_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB_IDLE;
         owner_q    <= '0;
         last_owner <= OW'(NUM_MASTERS - 1);
      end else begin
         unique case (state)
            ARB_IDLE: begin
               if (any_req) begin
                  state   <= ARB_GRANT;
                  owner_q <= winner;
               end
            end
            // GRANT and WAIT share one tree; they differ only in how a missing strobe is read.
            ARB_GRANT, ARB_WAIT: begin
               if (timeout_hit || (!strobe && (state == ARB_WAIT || !req[owner_q]))) begin
                  state      <= ARB_IDLE;
                  last_owner <= owner_q;
               end else if (strobe && bus_hit) begin
                  if (bus_read) begin
                     state <= ARB_DATA;
                  end else if (keep) begin
                     state <= ARB_GRANT;
                  end else begin
                     state      <= ARB_IDLE;
                     last_owner <= owner_q;
                  end
               end else if (strobe) begin
                  state <= ARB_WAIT;
               end
            end
            ARB_DATA: begin
               if (keep) begin
                  state <= ARB_GRANT;
               end else begin
                  state      <= ARB_IDLE;
                  last_owner <= owner_q;
               end
            end
         endcase
      end
   end

`ifdef ARILLA_ARB_TIMEOUT_EN
   localparam int unsigned CW = (clog2_min1(TIMEOUT_CYCLES) < 5) ? 5 : clog2_min1(TIMEOUT_CYCLES);

   logic [CW-1:0] wait_cnt;

   assign timeout_hit = (state == ARB_WAIT) && strobe && !bus_hit &&
                        (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt  <= '0;
         bus_error <= 1'b0;
      end else begin
         bus_error <= timeout_hit;
         if (state != ARB_WAIT) wait_cnt <= '0;
         else                   wait_cnt <= wait_cnt + CW'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign bus_error   = 1'b0;
   // TIMEOUT_CYCLES is consumed only by the watchdog build.
   if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
   end
`endif

   assign busy  = (state != ARB_IDLE);
   assign owner = owner_q;

   always_comb begin
      available = '0;
      if (busy) available[owner_q] = 1'b1;
   end

endmodule
